// File: rtl/prio_enc_pkg.sv
// Shared types and encode helpers for the pipelined priority encoder.
// Request vectors are zero-extended to MaxN bits so the helpers serve any N <= MaxN.
package prio_enc_pkg;

    localparam int unsigned MaxN = 256;
    localparam int unsigned MaxW = $clog2(MaxN);

    typedef struct packed {
        logic [MaxW-1:0] y;
        logic            any;
        logic            err_multi;
    } result_t;

    // True when more than one request bit is set.
    function automatic logic multi_hot(logic [MaxN-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < int'(MaxN); i++) begin
            if (v[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
            end
        end
        return multi;
    endfunction

    // Last match in scan order wins, so the scan direction selects the priority.
    function automatic result_t encode(logic [MaxN-1:0] v, bit msb_first);
        result_t r;
        int      j;
        r = '0;
        for (int i = 0; i < int'(MaxN); i++) begin
            j = msb_first ? i : int'(MaxN) - 1 - i;
            if (v[j]) begin
                r.y = MaxW'(j);
            end
        end
        r.any       = |v;
        r.err_multi = multi_hot(v);
        return r;
    endfunction

endpackage

// File: rtl/prio_encoder_pipe_if.sv
// Request/result bundle for prio_encoder_pipe.
// err_multi/err_seen exist only when PRIO_ENC_MULTIHOT_CHK_EN is defined.
interface prio_encoder_pipe_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned W = $clog2(N);

    logic         en;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] din;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         any;
`ifdef PRIO_ENC_MULTIHOT_CHK_EN
    logic         err_multi;
    logic         err_seen;

    modport master (
        output en, in_valid, din, out_ready,
        input  in_ready, out_valid, y, any, err_multi, err_seen
    );
    modport slave (
        input  en, in_valid, din, out_ready,
        output in_ready, out_valid, y, any, err_multi, err_seen
    );
`else
    modport master (
        output en, in_valid, din, out_ready,
        input  in_ready, out_valid, y, any
    );
    modport slave (
        input  en, in_valid, din, out_ready,
        output in_ready, out_valid, y, any
    );
`endif

endinterface

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready skid buffer: output register plus one skid register.
// FIFO order, 1 item/cycle throughput, in_ready depends only on skid occupancy.
module skid_buf2 #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data
);

    logic             out_valid_q, out_valid_d;
    logic [Width-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [Width-1:0] skid_data_q, skid_data_d;
    logic             push, pop;

    assign in_ready  = ~skid_valid_q;
    assign push      = in_valid & ~skid_valid_q;
    assign pop       = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            // Full: no push possible; a transfer promotes the skid entry.
            if (pop) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (push) begin
            if (!out_valid_q || pop) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/prio_encoder_pipe.sv
// N:log2(N) priority encoder with a registered, skid-buffered valid/ready output.
// Define PRIO_ENC_MULTIHOT_CHK_EN to add err_multi/err_seen multi-hot reporting.
module prio_encoder_pipe
    import prio_enc_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    prio_encoder_pipe_if.slave bus
);

    localparam int unsigned W = $clog2(N);
`ifdef PRIO_ENC_MULTIHOT_CHK_EN
    localparam int unsigned PW = W + 2;
`else
    localparam int unsigned PW = W + 1;
`endif

    result_t       enc;
    logic          unused_enc;
    logic [PW-1:0] payload_in;
    logic [PW-1:0] payload_out;
    logic          skid_ready;

    assign enc        = encode(MaxN'(bus.din), MSB_FIRST);
    // Upper index bits are always zero for N < MaxN.
    assign unused_enc = ^enc;

`ifdef PRIO_ENC_MULTIHOT_CHK_EN
    assign payload_in = {enc.y[W-1:0], enc.any, enc.err_multi};
`else
    assign payload_in = {enc.y[W-1:0], enc.any};
`endif

    skid_buf2 #(
        .Width(PW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.in_valid & bus.en),
        .in_ready (skid_ready),
        .in_data  (payload_in),
        .out_valid(bus.out_valid),
        .out_ready(bus.out_ready),
        .out_data (payload_out)
    );

    assign bus.in_ready = bus.en & skid_ready;
    assign bus.y        = payload_out[PW-1 -: W];
    assign bus.any      = payload_out[PW-W-1];

`ifdef PRIO_ENC_MULTIHOT_CHK_EN
    logic err_seen_q, err_seen_d;

    always_comb begin
        err_seen_d = err_seen_q;
        if (bus.in_valid && bus.en && skid_ready && enc.err_multi) begin
            err_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_seen_q <= 1'b0;
        end else begin
            err_seen_q <= err_seen_d;
        end
    end

    assign bus.err_multi = payload_out[0];
    assign bus.err_seen  = err_seen_q;
`endif

endmodule
